// File: rtl/hex_string_streamer_if.sv
// Handshake bundle between the word producer, the hex streamer and the character sink.
interface hex_string_streamer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             upper;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_last;

  modport master (
    output in_valid, in_value, upper, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );

  modport slave (
    input  in_valid, in_value, upper, out_ready,
    output in_ready, out_valid, out_char, out_last
  );
endinterface

// File: rtl/hex_string_streamer.sv
// Streams a WIDTH-bit word as hex ASCII, MSB nibble first, optionally prefixed by "0x".
// Optional macro HEX_STRING_STREAMER_ZERO_SUPPRESS_EN drops leading zero digits.
module hex_string_streamer #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          PREFIX = 1'b0
) (
  input logic                clk,
  input logic                rst,
  hex_string_streamer_if.slave io
);
  localparam int unsigned NDIGITS = WIDTH / 4;
  localparam int unsigned CW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {IDLE, PFX0, PFX1, DIGIT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             upper_q, upper_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_char_q, out_char_d;
  logic             out_last_q, out_last_d;
  logic [CW-1:0]    start_idx;
  logic [CW-1:0]    idx_dec;

  function automatic logic [7:0] hex_char(input logic [3:0] n, input logic up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    // 8'h37 + 10 = "A", 8'h57 + 10 = "a"
    return (up ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  function automatic logic [3:0] nib(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
    logic [WIDTH-1:0] s;
    s = w >> {i, 2'b00};
    return s[3:0];
  endfunction

  // Index of the first digit to emit for the word being offered
  always_comb begin
`ifdef HEX_STRING_STREAMER_ZERO_SUPPRESS_EN
    start_idx = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (io.in_value[4*i +: 4] != 4'h0) start_idx = CW'(i);
    end
`else
    start_idx = CW'(NDIGITS - 1);
`endif
  end

  assign idx_dec = idx_q - CW'(1);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    upper_d     = upper_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          word_d      = io.in_value;
          upper_d     = io.upper;
          idx_d       = start_idx;
          out_valid_d = 1'b1;
          if (PREFIX) begin
            state_d    = PFX0;
            out_char_d = 8'h30;
            out_last_d = 1'b0;
          end else begin
            state_d    = DIGIT;
            out_char_d = hex_char(nib(io.in_value, start_idx), io.upper);
            out_last_d = (start_idx == '0);
          end
        end
      end
      PFX0: begin
        if (io.out_ready) begin
          state_d    = PFX1;
          out_char_d = 8'h78;
        end
      end
      PFX1: begin
        if (io.out_ready) begin
          state_d    = DIGIT;
          out_char_d = hex_char(nib(word_q, idx_q), upper_q);
          out_last_d = (idx_q == '0);
        end
      end
      DIGIT: begin
        if (io.out_ready) begin
          if (idx_q == '0) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_char_d  = 8'h00;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_dec;
            out_char_d = hex_char(nib(word_q, idx_dec), upper_q);
            out_last_d = (idx_dec == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      upper_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      upper_q     <= upper_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_char  = out_char_q;
  assign io.out_last  = out_last_q;
endmodule

// File: tb/tb_hex_string_streamer.sv
// Scoreboard bench: drivers push expected {last,char} strings, per-instance monitors pop on each transfer.
module tb_hex_string_streamer;
  logic clk;
  logic rst;

  hex_string_streamer_if #(.WIDTH(32)) b32 ();
  hex_string_streamer_if #(.WIDTH(16)) b16 ();
  hex_string_streamer_if #(.WIDTH(8))  b8 ();
  hex_string_streamer_if #(.WIDTH(4))  b4 ();

  hex_string_streamer #(.WIDTH(32), .PREFIX(1'b0)) u32 (.clk(clk), .rst(rst), .io(b32));
  hex_string_streamer #(.WIDTH(16), .PREFIX(1'b1)) u16 (.clk(clk), .rst(rst), .io(b16));
  hex_string_streamer #(.WIDTH(8),  .PREFIX(1'b0)) u8  (.clk(clk), .rst(rst), .io(b8));
  hex_string_streamer #(.WIDTH(4),  .PREFIX(1'b0)) u4  (.clk(clk), .rst(rst), .io(b4));

  logic [8:0] q32[$];
  logic [8:0] q16[$];
  logic [8:0] q8[$];
  logic [8:0] q4[$];

  int n_pass  = 0;
  int n_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int w, input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [8:0] e;
      e = {(i == s.len() - 1), s[i]};
      case (w)
        0: q32.push_back(e);
        1: q16.push_back(e);
        2: q8.push_back(e);
        default: q4.push_back(e);
      endcase
    end
  endtask

  function automatic logic ready(input int w);
    case (w)
      0: return b32.in_ready;
      1: return b16.in_ready;
      2: return b8.in_ready;
      default: return b4.in_ready;
    endcase
  endfunction

  // Offer one word; returns 1 time unit after the accepting edge.
  task automatic send(input int w, input logic [31:0] v, input logic up, input string s);
    int n;
    n = 0;
    @(negedge clk);
    push(w, s);
    case (w)
      0: begin b32.in_valid = 1'b1; b32.in_value = v;        b32.upper = up; end
      1: begin b16.in_valid = 1'b1; b16.in_value = v[15:0];  b16.upper = up; end
      2: begin b8.in_valid  = 1'b1; b8.in_value  = v[7:0];   b8.upper  = up; end
      default: begin b4.in_valid = 1'b1; b4.in_value = v[3:0]; b4.upper = up; end
    endcase
    while (!ready(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept ready w%0d", w), 32'(ready(w)), 32'd1);
    @(posedge clk);
    #1;
    case (w)
      0: begin b32.in_valid = 1'b0; b32.in_value = ~v;       b32.upper = ~up; end
      1: begin b16.in_valid = 1'b0; b16.in_value = ~v[15:0]; b16.upper = ~up; end
      2: begin b8.in_valid  = 1'b0; b8.in_value  = ~v[7:0];  b8.upper  = ~up; end
      default: begin b4.in_valid = 1'b0; b4.in_value = ~v[3:0]; b4.upper = ~up; end
    endcase
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && (q32.size() != 0 || q16.size() != 0 || q8.size() != 0 || q4.size() != 0 ||
                       b32.out_valid || b16.out_valid || b8.out_valid || b4.out_valid)) begin
      @(negedge clk);
      n++;
    end
    check("drain within budget", 32'(n < 300), 32'd1);
  endtask

  // Monitors: compare each transferred character against the scoreboard head
  always @(negedge clk) begin
    if (!rst && b32.out_valid && b32.out_ready) begin
      logic [8:0] e;
      e = (q32.size() > 0) ? q32.pop_front() : 9'h1FF;
      check("u32 {last,char}", 32'({b32.out_last, b32.out_char}), 32'(e));
    end
  end
  always @(negedge clk) begin
    if (!rst && b16.out_valid && b16.out_ready) begin
      logic [8:0] e;
      e = (q16.size() > 0) ? q16.pop_front() : 9'h1FF;
      check("u16 {last,char}", 32'({b16.out_last, b16.out_char}), 32'(e));
    end
  end
  always @(negedge clk) begin
    if (!rst && b8.out_valid && b8.out_ready) begin
      logic [8:0] e;
      e = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
      check("u8 {last,char}", 32'({b8.out_last, b8.out_char}), 32'(e));
    end
  end
  always @(negedge clk) begin
    if (!rst && b4.out_valid && b4.out_ready) begin
      logic [8:0] e;
      e = (q4.size() > 0) ? q4.pop_front() : 9'h1FF;
      check("u4 {last,char}", 32'({b4.out_last, b4.out_char}), 32'(e));
    end
  end

  initial begin
    int busy;
    rst = 1'b0;
    b32.in_valid = 1'b0; b32.in_value = '0; b32.upper = 1'b0; b32.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_value = '0; b16.upper = 1'b0; b16.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.in_value  = '0; b8.upper  = 1'b0; b8.out_ready  = 1'b1;
    b4.in_valid  = 1'b0; b4.in_value  = '0; b4.upper  = 1'b0; b4.out_ready  = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("reset in_ready", 32'(b32.in_ready), 32'd1);
    check("reset out_valid", 32'(b32.out_valid), 32'd0);
    check("reset out_char", 32'(b32.out_char), 32'h00);
    check("reset out_last", 32'(b16.out_last), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full-rate stream, latency 1, bubble before in_ready returns
    send(0, 32'hDEADBEEF, 1'b0, "deadbeef");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("deadbeef valid c%0d", i), 32'(b32.out_valid), 32'd1);
    end
    @(negedge clk);
    check("deadbeef bubble valid", 32'(b32.out_valid), 32'd0);
    check("deadbeef in_ready back", 32'(b32.in_ready), 32'd1);

    send(1, 32'h0A5C, 1'b1, "0x0A5C");
    drain();

    // Backpressure: out_ready 1,0,0,1,1 from the first valid cycle
    send(2, 32'h3F, 1'b0, "3f");
    @(posedge clk); #1 b8.out_ready = 1'b0;
    @(negedge clk);
    check("stall1 char", 32'({b8.out_valid, b8.out_last, b8.out_char}), 32'h366);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall2 char", 32'({b8.out_valid, b8.out_last, b8.out_char}), 32'h366);
    @(posedge clk); #1 b8.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall end valid", 32'(b8.out_valid), 32'd0);
    check("stall q8 empty", 32'(q8.size()), 32'd0);

    // in_valid held with junk while busy; next word only after the bubble
    send(0, 32'hCAFEF00D, 1'b0, "cafef00d");
    b32.in_valid = 1'b1;
    busy = 0;
    forever begin
      @(negedge clk);
      if (b32.in_ready || busy >= 50) break;
      busy++;
      b32.in_value = $urandom;
      b32.upper = 1'($urandom);
    end
    check("busy cycles", 32'(busy), 32'd8);
    check("bubble out_valid", 32'(b32.out_valid), 32'd0);
    b32.in_value = 32'h89ABCDEF;
    b32.upper = 1'b1;
    push(0, "89ABCDEF");
    @(posedge clk); #1 b32.in_valid = 1'b0;
    @(negedge clk);
    check("second word valid", 32'(b32.out_valid), 32'd1);
    drain();

    // Async reset with the third digit pending
    send(0, 32'h12345678, 1'b0, "12345678");
    @(posedge clk); #1;
    @(posedge clk); #1 b32.out_ready = 1'b0;
    @(negedge clk);
    check("pending 3rd digit", 32'({b32.out_valid, b32.out_char}), 32'h133);
    #2 rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(b32.out_valid), 32'd0);
    check("midrst in_ready", 32'(b32.in_ready), 32'd1);
    check("midrst out_last", 32'(b32.out_last), 32'd0);
    q32.delete();
    @(negedge clk);
    rst = 1'b0;
    b32.out_ready = 1'b1;
    send(0, 32'hA1B2C3D4, 1'b0, "a1b2c3d4");
    drain();

`ifdef HEX_STRING_STREAMER_ZERO_SUPPRESS_EN
    send(0, 32'h000000A0, 1'b0, "a0");
    send(0, 32'h00000000, 1'b0, "0");
    send(1, 32'h0000, 1'b0, "0x0");
`else
    send(0, 32'h000000A0, 1'b0, "000000a0");
    send(0, 32'h00000000, 1'b0, "00000000");
    send(1, 32'h0000, 1'b0, "0x0000");
`endif
    send(3, 32'hB, 1'b1, "B");
    send(3, 32'h0, 1'b0, "0");
    drain();

    check("final q32 empty", 32'(q32.size()), 32'd0);
    check("final q16 empty", 32'(q16.size()), 32'd0);
    check("final q4 empty", 32'(q4.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
